// File: rtl/iic_byte_ctrl.sv
// iic_byte_ctrl: byte-level IIC master sequencer (START/STOP/WRITE/READ) stepped by baud phase ticks.
// Optional IIC_CLK_STRETCH_EN: hold DATA/ACK phase 2 while a slave keeps SCL low.
module iic_byte_ctrl (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_wdata,
    input  logic       cmd_nack,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_STOP, S_DATA, S_ACK} state_t;
    state_t     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] data_q, data_d, rdata_q, rdata_d;
    logic       rd_q, rd_d, nack_q, nack_d, rnack_q, rnack_d, valid_q, valid_d;
    logic       scl_q, scl_d, sda_q, sda_d;
    logic       stall, adv, slot_sda;

`ifdef IIC_CLK_STRETCH_EN
    assign stall = (state_q == S_DATA || state_q == S_ACK) && phase_q == 2'd2 && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign stall = 1'b0;
`endif
    assign adv = baud_tick && state_q != S_IDLE && !stall;
    // data_q holds the WRITE byte, or collects the READ byte MSB first
    assign slot_sda = state_q == S_DATA ? !rd_q && !data_q[bit_cnt_q] : rd_q && !nack_q;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        rdata_d   = rdata_q;
        rd_d      = rd_q;
        nack_d    = nack_q;
        rnack_d   = rnack_q;
        valid_d   = 1'b0;
        scl_d     = scl_q;
        sda_d     = sda_q;
        if (cmd_valid && state_q == S_IDLE) begin
            rd_d      = cmd_op[0];
            data_d    = cmd_wdata;
            nack_d    = cmd_nack;
            rnack_d   = 1'b0;
            phase_d   = 2'd0;
            bit_cnt_d = 3'd7;
            state_d   = cmd_op == 2'b00 ? S_START : cmd_op == 2'b01 ? S_STOP : S_DATA;
        end else if (adv) begin
            phase_d = phase_q + 2'd1;
            case (state_q)
                S_START: begin
                    case (phase_q)
                        2'd0: sda_d = 1'b0;
                        2'd1: scl_d = 1'b0;
                        2'd2: sda_d = 1'b1;
                        default: begin
                            scl_d   = 1'b1;
                            state_d = S_IDLE;
                            valid_d = 1'b1;
                        end
                    endcase
                end
                S_STOP: begin
                    case (phase_q)
                        2'd0: begin
                            scl_d = 1'b1;
                            sda_d = 1'b1;
                        end
                        2'd1: scl_d = 1'b0;
                        2'd2: sda_d = 1'b0;
                        default: begin
                            state_d = S_IDLE;
                            valid_d = 1'b1;
                        end
                    endcase
                end
                S_DATA, S_ACK: begin
                    case (phase_q)
                        2'd0: begin
                            scl_d = 1'b1;
                            sda_d = slot_sda;
                        end
                        2'd1: scl_d = 1'b0;
                        2'd2: begin
                            if (state_q == S_DATA && rd_q) data_d = {data_q[6:0], sda_in};
                            if (state_q == S_ACK && !rd_q) rnack_d = sda_in;
                        end
                        default: begin
                            scl_d = 1'b1;
                            if (state_q == S_ACK) begin
                                state_d = S_IDLE;
                                valid_d = 1'b1;
                                if (rd_q) rdata_d = data_q;
                            end else if (bit_cnt_q == 3'd0) begin
                                state_d = S_ACK;
                            end else begin
                                bit_cnt_d = bit_cnt_q - 3'd1;
                            end
                        end
                    endcase
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            phase_q   <= 2'd0;
            bit_cnt_q <= 3'd7;
            data_q    <= 8'h00;
            rdata_q   <= 8'h00;
            rd_q      <= 1'b0;
            nack_q    <= 1'b0;
            rnack_q   <= 1'b0;
            valid_q   <= 1'b0;
            scl_q     <= 1'b0;
            sda_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            rdata_q   <= rdata_d;
            rd_q      <= rd_d;
            nack_q    <= nack_d;
            rnack_q   <= rnack_d;
            valid_q   <= valid_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
        end
    end

    assign cmd_ready = state_q == S_IDLE;
    assign rsp_valid = valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_nack  = rnack_q;
    assign scl_oe    = scl_q;
    assign sda_oe    = sda_q;
endmodule
